// File: rtl/bp_update_arbiter.sv
// bp_update_arbiter: merges resolved-branch updates from two branch units into
// one in-order stream of PHT/GHR updates for the predictor.
//   - Two requesters (req0/req1) are arbitrated round-robin, one grant per
//     cycle; reqN_ready is the combinational grant.
//   - Granted updates {pht_index, taken} queue in a DEPTH-entry FIFO and are
//     presented on upd_* with a valid/ready handshake.
//   - stall_count counts cycles with a valid-but-not-granted request and
//     saturates at 255.
// Optional feature: define BP_UPD_BYPASS_EN to forward a grant straight to
// upd_* in the same cycle when the FIFO is empty.
// Ports:
//   clock, reset                              clock, synchronous active-high reset
//   req0_valid/req0_pht_index/req0_taken      branch unit 0 request
//   req0_ready                                unit 0 grant (combinational)
//   req1_*                                    same for branch unit 1
//   upd_valid/upd_pht_index/upd_taken         update presented to predictor
//   upd_ready                                 predictor consumes update
//   stall_count                               saturating lost-request cycle count
module bp_update_arbiter #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [4:0] req0_pht_index,
  input  logic       req0_taken,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [4:0] req1_pht_index,
  input  logic       req1_taken,
  output logic       req1_ready,
  output logic       upd_valid,
  output logic [4:0] upd_pht_index,
  output logic       upd_taken,
  input  logic       upd_ready,
  output logic [7:0] stall_count
);

  localparam int unsigned IDX_W   = 5;
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned STALL_W = 8;

  typedef struct packed {
    logic [IDX_W-1:0] pht_index;
    logic             taken;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   count;
  logic               last_grant;  // 1 = req1 was granted most recently

  logic   not_full;
  logic   grant0;
  logic   grant1;
  logic   fifo_valid;
  logic   bypass;
  logic   push;
  logic   pop;
  logic   stall_evt;
  entry_t win_entry;
  entry_t out_entry;

  // Arbitration, output selection and FIFO control
  always_comb begin
    not_full   = 1'b0;
    grant0     = 1'b0;
    grant1     = 1'b0;
    fifo_valid = 1'b0;
    bypass     = 1'b0;
    win_entry  = '0;
    out_entry  = '0;

    // Full blocks grants even when a pop happens this cycle
    not_full   = !reset && (count < CNT_W'(DEPTH));
    grant0     = not_full && req0_valid && (!req1_valid || last_grant);
    grant1     = not_full && req1_valid && (!req0_valid || !last_grant);
    win_entry  = grant1 ? entry_t'{req1_pht_index, req1_taken}
                        : entry_t'{req0_pht_index, req0_taken};
    fifo_valid = !reset && (count != '0);
`ifdef BP_UPD_BYPASS_EN
    bypass     = !reset && (count == '0) && (grant0 || grant1);
`else
    bypass     = 1'b0;
`endif
    if (fifo_valid) begin
      out_entry = mem[rd_ptr];
    end else if (bypass) begin
      out_entry = win_entry;
    end

    // A bypassed update consumed immediately never enters the FIFO
    push      = (grant0 || grant1) && !(bypass && upd_ready);
    pop       = fifo_valid && upd_ready;
    stall_evt = (req0_valid && !grant0) || (req1_valid && !grant1);
  end

  assign req0_ready    = grant0;
  assign req1_ready    = grant1;
  assign upd_valid     = fifo_valid || bypass;
  assign upd_pht_index = out_entry.pht_index;
  assign upd_taken     = out_entry.taken;

  // Pointers, occupancy, round-robin state and stall counter
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      last_grant  <= 1'b1;
      stall_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (grant0) begin
        last_grant <= 1'b0;
      end else if (grant1) begin
        last_grant <= 1'b1;
      end
      if (stall_evt && (stall_count != {STALL_W{1'b1}})) begin
        stall_count <= stall_count + STALL_W'(1);
      end
    end
  end

  // FIFO storage; no reset needed, occupancy tracks validity
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= win_entry;
    end
  end

endmodule

// File: tb/tb_bp_update_arbiter.sv
// Bench for bp_update_arbiter: table vectors for tie/fill/full corner cases,
// then model-driven wrap, saturation, reset and bypass sequences. Every grant
// the bench expects pushes {index, taken} into a scoreboard queue that is
// popped and compared whenever the DUT hands an update to the predictor.
module tb_bp_update_arbiter;

  localparam int DEPTH = 4;

  logic       clock;
  logic       reset;
  logic       req0_valid;
  logic [4:0] req0_pht_index;
  logic       req0_taken;
  logic       req0_ready;
  logic       req1_valid;
  logic [4:0] req1_pht_index;
  logic       req1_taken;
  logic       req1_ready;
  logic       upd_valid;
  logic [4:0] upd_pht_index;
  logic       upd_taken;
  logic       upd_ready;
  logic [7:0] stall_count;

  bp_update_arbiter #(.DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .req0_valid     (req0_valid),
    .req0_pht_index (req0_pht_index),
    .req0_taken     (req0_taken),
    .req0_ready     (req0_ready),
    .req1_valid     (req1_valid),
    .req1_pht_index (req1_pht_index),
    .req1_taken     (req1_taken),
    .req1_ready     (req1_ready),
    .upd_valid      (upd_valid),
    .upd_pht_index  (upd_pht_index),
    .upd_taken      (upd_taken),
    .upd_ready      (upd_ready),
    .stall_count    (stall_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic       rst;
    logic       r0v;
    logic [4:0] r0i;
    logic       r0t;
    logic       r1v;
    logic [4:0] r1i;
    logic       r1t;
    logic       ur;
    logic       e0;
    logic       e1;
    logic       euv;
    logic [7:0] est;
  } vec_t;

  logic [5:0] sb[$];
  int n_cmp = 0;
  int n_err = 0;

  // Reference occupancy / round-robin / stall state for model-driven sequences
  int m_cnt   = 0;
  bit m_last  = 1'b1;
  int m_stall = 0;

  function automatic vec_t mk(input int rst, input int r0v, input int r0i, input int r0t,
                              input int r1v, input int r1i, input int r1t, input int ur,
                              input int e0, input int e1, input int euv, input int est);
    vec_t v;
    v.rst = 1'(rst); v.r0v = 1'(r0v); v.r0i = 5'(r0i); v.r0t = 1'(r0t);
    v.r1v = 1'(r1v); v.r1i = 5'(r1i); v.r1t = 1'(r1t); v.ur  = 1'(ur);
    v.e0  = 1'(e0);  v.e1  = 1'(e1);  v.euv = 1'(euv); v.est = 8'(est);
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Drive one cycle at the falling edge, check combinational and registered
  // outputs just after, then run the scoreboard.
  task automatic step(input vec_t v);
    logic [5:0] exp_e;
    @(negedge clock);
    reset          = v.rst;
    req0_valid     = v.r0v;
    req0_pht_index = v.r0i;
    req0_taken     = v.r0t;
    req1_valid     = v.r1v;
    req1_pht_index = v.r1i;
    req1_taken     = v.r1t;
    upd_ready      = v.ur;
    #1;
    check("req0_ready",  int'(req0_ready),  int'(v.e0));
    check("req1_ready",  int'(req1_ready),  int'(v.e1));
    check("upd_valid",   int'(upd_valid),   int'(v.euv));
    check("stall_count", int'(stall_count), int'(v.est));
    if (v.rst) begin
      sb.delete();
    end else begin
      if (v.e0 && v.r0v) sb.push_back({v.r0i, v.r0t});
      if (v.e1 && v.r1v) sb.push_back({v.r1i, v.r1t});
    end
    if (upd_valid && v.ur && !v.rst) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL upd_unexpected at %0t: got idx %0d taken %0d, expected no update",
                 $time, upd_pht_index, upd_taken);
      end else begin
        exp_e = sb.pop_front();
        check("upd_fields", int'({upd_pht_index, upd_taken}), int'(exp_e));
      end
    end else if (!upd_valid) begin
      check("upd_idle_zero", int'({upd_pht_index, upd_taken}), 0);
    end
  endtask

  // Build expectations from the reference state, apply, then advance state
  task automatic run_model(input int rst, input int r0v, input int r0i, input int r0t,
                           input int r1v, input int r1i, input int r1t, input int ur,
                           output int got0);
    bit can, g0, g1, fuv, byp, uv;
    can = (rst == 0) && (m_cnt < DEPTH);
    g0  = can && (r0v != 0) && ((r1v == 0) || m_last);
    g1  = can && (r1v != 0) && ((r0v == 0) || !m_last);
    fuv = (rst == 0) && (m_cnt != 0);
`ifdef BP_UPD_BYPASS_EN
    byp = (rst == 0) && (m_cnt == 0) && (g0 || g1);
`else
    byp = 1'b0;
`endif
    uv = fuv || byp;
    step(mk(rst, r0v, r0i, r0t, r1v, r1i, r1t, ur, int'(g0), int'(g1), int'(uv), m_stall));
    if (rst != 0) begin
      m_cnt   = 0;
      m_last  = 1'b1;
      m_stall = 0;
    end else begin
      if ((((r0v != 0) && !g0) || ((r1v != 0) && !g1)) && (m_stall < 255)) m_stall++;
      m_cnt = m_cnt + int'((g0 || g1) && !(byp && (ur != 0))) - int'(fuv && (ur != 0));
      if (g0) m_last = 1'b0;
      else if (g1) m_last = 1'b1;
    end
    got0 = int'(g0);
  endtask

  initial begin
    vec_t vecs[$];
    int   g;
    int   k;
    int   cyc;

    reset = 1'b1;
    req0_valid = 1'b0; req0_pht_index = '0; req0_taken = 1'b0;
    req1_valid = 1'b0; req1_pht_index = '0; req1_taken = 1'b0;
    upd_ready = 1'b0;
    repeat (2) @(negedge clock);

`ifndef BP_UPD_BYPASS_EN
    //          rst r0v r0i r0t r1v r1i r1t ur  e0 e1 uv stall
    vecs.push_back(mk(1, 1, 3, 1, 1, 7, 0, 1,  0, 0, 0, 0));  // reset: no grants
    vecs.push_back(mk(0, 1, 3, 1, 1, 7, 0, 1,  1, 0, 0, 0));  // tie -> req0
    vecs.push_back(mk(0, 0, 0, 0, 1, 7, 0, 1,  0, 1, 1, 1));  // req1, {3,1} out
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 1));  // {7,0} out
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 1));  // empty
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0,  1, 0, 0, 1));  // fill 1
    vecs.push_back(mk(0, 1, 2, 0, 0, 0, 0, 0,  1, 0, 1, 1));  // fill 2
    vecs.push_back(mk(0, 1, 3, 1, 0, 0, 0, 0,  1, 0, 1, 1));  // fill 3
    vecs.push_back(mk(0, 1, 4, 0, 0, 0, 0, 0,  1, 0, 1, 1));  // fill 4 -> full
    vecs.push_back(mk(0, 1, 5, 1, 0, 0, 0, 0,  0, 0, 1, 1));  // held, stalls
    vecs.push_back(mk(0, 1, 5, 1, 0, 0, 0, 0,  0, 0, 1, 2));
    vecs.push_back(mk(0, 1, 5, 1, 0, 0, 0, 0,  0, 0, 1, 3));
    vecs.push_back(mk(0, 1, 5, 1, 1, 12, 1, 1, 0, 0, 1, 4));  // full with pop: no grant
    vecs.push_back(mk(0, 1, 5, 1, 1, 12, 1, 0, 0, 1, 1, 5));  // count 3: req1 wins RR
    vecs.push_back(mk(0, 1, 5, 1, 0, 0, 0, 1,  0, 0, 1, 6));  // full again, pop
    vecs.push_back(mk(0, 1, 5, 1, 0, 0, 0, 1,  1, 0, 1, 7));  // push+pop
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 7));  // drain
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 7));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 7));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 7));  // empty again
    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);
    m_cnt = 0; m_last = 1'b0; m_stall = 7;
`else
    // Empty FIFO bypass: same-cycle update, nothing left behind
    run_model(0, 1, 9, 1, 0, 0, 0, 1, g);
    run_model(0, 0, 0, 0, 0, 0, 0, 1, g);
    // Bypass not consumed: becomes the head entry
    run_model(0, 1, 10, 0, 0, 0, 0, 0, g);
    run_model(0, 0, 0, 0, 0, 0, 0, 1, g);
    run_model(0, 1, 3, 1, 1, 7, 0, 1, g);
    run_model(0, 0, 0, 0, 1, 7, 0, 1, g);
    run_model(0, 0, 0, 0, 0, 0, 0, 1, g);
`endif

    // Wrap: 10 updates with upd_ready toggling every cycle
    k = 0;
    cyc = 0;
    while ((k < 10 || m_cnt != 0 || sb.size() != 0) && cyc < 80) begin
      run_model(0, int'(k < 10), k + 16, k % 2, 0, 0, 0, int'(cyc % 2 == 0), g);
      k += g;
      cyc++;
    end
    check("wrap_done_in_budget", int'(cyc < 80), 1);
    check("wrap_scoreboard_empty", sb.size(), 0);
    run_model(0, 0, 0, 0, 0, 0, 0, 1, g);

    // Saturation: req0 held against a full FIFO
    for (int i = 0; i < 300; i++) run_model(0, 1, 20, 0, 0, 0, 0, 0, g);
    check("stall_saturated", int'(stall_count), 255);
    run_model(0, 1, 20, 0, 0, 0, 0, 1, g);   // one pop -> 3 pending
    check("stall_still_255", int'(stall_count), 255);
    run_model(1, 0, 0, 0, 0, 0, 0, 1, g);    // reset discards pending entries
    run_model(0, 0, 0, 0, 0, 0, 0, 1, g);    // behaves empty, stall cleared
    check("post_reset_stall", int'(stall_count), 0);
    run_model(0, 1, 3, 1, 1, 7, 0, 1, g);    // req0 wins first tie again
    run_model(0, 0, 0, 0, 1, 7, 0, 1, g);
    run_model(0, 0, 0, 0, 0, 0, 0, 1, g);
    run_model(0, 0, 0, 0, 0, 0, 0, 1, g);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bp_update_arbiter.md
BP_UPDATE_ARBITER -- requirements
Module: bp_update_arbiter

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of pending-update FIFO entries; legal values are 2, 4 and 8.
REQ-002 clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-004 req0_valid  input  1  SHALL indicate that branch unit 0 presents a resolved conditional branch.
REQ-005 req0_pht_index  input  5  SHALL carry the PHT index captured at prediction time for unit 0.
REQ-006 req0_taken  input  1  SHALL carry the resolved direction for unit 0 (1 = taken).
REQ-007 req0_ready  output  1  SHALL be high in the cycle unit 0's update is accepted.
REQ-008 req1_valid, req1_pht_index, req1_taken, req1_ready SHALL mirror REQ-004..007 for branch unit 1.
REQ-009 upd_valid  output  1  SHALL indicate that a PHT/GHR update is presented to the predictor.
REQ-010 upd_pht_index  output  5  SHALL carry the PHT index of the presented update.
REQ-011 upd_taken  output  1  SHALL carry the direction of the presented update.
REQ-012 upd_ready  input  1  SHALL indicate that the predictor consumes the presented update this cycle.
REQ-013 stall_count  output  8  SHALL count lost-request cycles as defined in REQ-022.

Function
REQ-014 Handshake: a transfer SHALL occur on a port exactly when its valid and ready are both high at a rising edge; requesters SHALL hold valid, index and taken stable until ready.
REQ-015 Each FIFO entry SHALL be {pht_index[4:0], taken}; entries SHALL leave in arrival order.
REQ-016 At most one requester SHALL be granted per cycle, and only when count < DEPTH; reqN_ready SHALL be the combinational grant.
REQ-017 Arbitration SHALL be round-robin: with one valid requester, that requester wins; with both valid, the requester not granted last wins; the last-granted pointer SHALL update only on a grant.
REQ-018 Without the feature in REQ-030, upd_valid SHALL be high exactly when count != 0, with head-entry fields; accept-to-upd_valid latency SHALL be 1 cycle.
REQ-019 A pop SHALL occur when upd_valid && upd_ready; push and pop in the same cycle SHALL leave count unchanged.
REQ-020 Full (count == DEPTH): both readys SHALL be low, even if a pop occurs in that cycle; count SHALL NOT exceed DEPTH.
REQ-021 Read and write pointers SHALL wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits wide.
REQ-022 stall_count SHALL increment by 1 in each cycle where (req0_valid && !req0_ready) || (req1_valid && !req1_ready), and SHALL saturate at 255.
REQ-023 With upd_valid low, upd_pht_index and upd_taken SHALL be 0.

Reset
REQ-024 Under reset, count, the pointers and stall_count SHALL clear to 0, and upd_valid SHALL be 0.
REQ-025 Under reset, the last-granted pointer SHALL be set to 1, so that req0 wins the first tie.
REQ-026 During any reset cycle, req0_ready and req1_ready SHALL be 0 and no push or pop SHALL occur.
REQ-027 Reset asserted mid-operation SHALL discard all pending entries; the first cycle after reset SHALL behave as empty.

Configuration
REQ-028 Macro BP_UPD_BYPASS_EN SHALL select the empty-FIFO bypass.
REQ-029 Without BP_UPD_BYPASS_EN, every update SHALL pass through the FIFO per REQ-018.
REQ-030 With BP_UPD_BYPASS_EN defined, when count == 0 and a grant occurs, the granted request's fields SHALL drive upd_* combinationally in the same cycle with upd_valid = 1.
REQ-031 With BP_UPD_BYPASS_EN, a bypassed update with upd_ready = 1 SHALL NOT be written to the FIFO; with upd_ready = 0 it SHALL be written as the head entry.

Verification
REQ-032 Tie: reset, then req0 {3, 1} and req1 {7, 0} both valid with upd_ready = 1 -> req0 granted in cycle 1, req1 in cycle 2; upd outputs are {3, 1} then {7, 0}.
REQ-033 Fill: DEPTH = 4, upd_ready = 0, req0 valid with indices 1..6 -> 4 accepts; req0_ready then 0; stall_count increments 1 per cycle while held; FIFO order is 1, 2, 3, 4.
REQ-034 Full with pop: full FIFO, upd_ready = 1 and req1 valid -> no grant that cycle; next cycle, count = 3 and req1 is granted.
REQ-035 Wrap: stream 10 updates with upd_ready toggling every cycle -> all 10 emerge in order and count returns to 0.
REQ-036 Saturation and reset: req0 held with FIFO full for 300 cycles -> stall_count = 255; reset asserted with 3 entries pending -> upd_valid = 0 and stall_count = 0 next cycle.
REQ-037 BP_UPD_BYPASS_EN defined: empty FIFO, req0 {9, 1}, upd_ready = 1 -> upd_valid = 1 and upd_pht_index = 9 in the same cycle, count stays 0; without the macro, they appear one cycle later.
